// File: rtl/mem_stage.sv
// Memory stage between EX and WB: waits for the data-SRAM response, aligns load data, absorbs flushes.
// Optional MS_FORWARD_EN adds the ms_forward bypass port toward ID.
module mem_stage #(
   parameter int ES_TO_MS_WD = 173,
   parameter int MS_TO_WS_WD = 168
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ws_allowin,
   output logic                   ms_allowin,
   input  logic                   es_to_ms_valid,
   input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
   output logic                   ms_to_ws_valid,
   output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
   input  logic                   data_sram_data_ok,
   input  logic [31:0]            data_sram_rdata,
   input  logic                   flush
`ifdef MS_FORWARD_EN
   ,
   output logic [71:0]            ms_forward
`endif
);

   logic                   ms_valid_q, ms_valid_d;
   logic [ES_TO_MS_WD-1:0] ms_bus_q, ms_bus_d;
   logic [31:0]            data_buf_q, data_buf_d;
   logic                   data_buf_valid_q, data_buf_valid_d;
   logic [1:0]             cancel_cnt_q, cancel_cnt_d;

   logic        req_issued, res_from_mem;
   logic [2:0]  load_op;
   logic [31:0] alu_result, rdata, load_data, final_result;
   logic        data_ok_live, ms_ready_go, ms_leave;

   assign req_issued   = ms_bus_q[169];
   assign res_from_mem = ms_bus_q[168];
   assign load_op      = ms_bus_q[172:170];
   assign alu_result   = ms_bus_q[71:40];

   // A response only belongs to this stage once all cancelled responses have drained.
   assign data_ok_live = data_sram_data_ok & (cancel_cnt_q == 2'd0);
   assign ms_ready_go  = ~req_issued | data_buf_valid_q | data_ok_live;
   assign ms_leave     = ms_valid_q & ms_ready_go & ws_allowin;

   assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
   assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;

   always_comb begin
      rdata     = data_buf_valid_q ? data_buf_q : data_sram_rdata;
      load_data = rdata;
      case (load_op)
         3'b001, 3'b010: begin
            logic [7:0] b;
            case (alu_result[1:0])
               2'd0:    b = rdata[7:0];
               2'd1:    b = rdata[15:8];
               2'd2:    b = rdata[23:16];
               default: b = rdata[31:24];
            endcase
            load_data = {{24{b[7] & ~load_op[1]}}, b};
         end
         3'b011, 3'b100: begin
            logic [15:0] h;
            h = alu_result[1] ? rdata[31:16] : rdata[15:0];
            load_data = {{16{h[15] & ~load_op[2]}}, h};
         end
         default: load_data = rdata;
      endcase
      final_result = res_from_mem ? load_data : alu_result;
   end

   assign ms_to_ws_bus = {ms_bus_q[167:72], final_result, ms_bus_q[39:0]};

`ifdef MS_FORWARD_EN
   assign ms_forward = {res_from_mem & ~ms_ready_go, ms_bus_q[31:0], final_result,
                        ms_bus_q[37:33], ms_bus_q[38], ms_valid_q};
`endif

   always_comb begin
      ms_valid_d       = flush ? 1'b0 : (ms_allowin ? es_to_ms_valid : ms_valid_q);
      ms_bus_d         = (es_to_ms_valid & ms_allowin) ? es_to_ms_bus : ms_bus_q;
      data_buf_d       = data_buf_q;
      data_buf_valid_d = data_buf_valid_q;
      cancel_cnt_d     = cancel_cnt_q;

      if (flush | ms_leave) begin
         data_buf_valid_d = 1'b0;
      end else if (ms_valid_q & req_issued & ~data_buf_valid_q & data_ok_live & ~ws_allowin) begin
         data_buf_valid_d = 1'b1;
         data_buf_d       = data_sram_rdata;
      end

      // A flush abandons an outstanding request whose response is still to come.
      if (flush) begin
         if (ms_valid_q & req_issued & ~data_buf_valid_q & ~data_sram_data_ok &
             (cancel_cnt_q != 2'd3))
            cancel_cnt_d = cancel_cnt_q + 2'd1;
      end else if (data_sram_data_ok & (cancel_cnt_q != 2'd0)) begin
         cancel_cnt_d = cancel_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q       <= 1'b0;
         ms_bus_q         <= '0;
         data_buf_q       <= '0;
         data_buf_valid_q <= 1'b0;
         cancel_cnt_q     <= 2'd0;
      end else begin
         ms_valid_q       <= ms_valid_d;
         ms_bus_q         <= ms_bus_d;
         data_buf_q       <= data_buf_d;
         data_buf_valid_q <= data_buf_valid_d;
         cancel_cnt_q     <= cancel_cnt_d;
      end
   end

endmodule
